// File: rtl/split_mux_rr_arb.sv
// Round-robin arbiter with downstream credit tracking; drives the one-hot sel bus of the split MUX.
// Optional burst lock is compiled in when SPLIT_MUX_ARB_LOCK_EN is defined.
module split_mux_rr_arb #(
    parameter int CNT     = 31,
    parameter int CREDITS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CNT-1:0]                   req,
    input  logic [CNT-1:0]                   last,
    input  logic                             credit_ret,
    output logic [CNT-1:0]                   gnt,
    output logic                             gnt_vld,
    output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
    output logic                             locked,
    output logic                             credit_err
);

    localparam int PW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_FULL = CW'(CREDITS);
    localparam logic [PW-1:0] LAST_IDX  = PW'(CNT - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;

    logic [PW-1:0] rr_idx;
    logic          rr_hit;
    logic [PW-1:0] sel_idx;
    logic          sel_hit;

    // Scan offsets from the far end down so the nearest requester after ptr_q is written last.
    always_comb begin
        int j;
        rr_idx = '0;
        rr_hit = 1'b0;
        j      = 0;
        for (int k = CNT - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= CNT) begin
                j = j - CNT;
            end
            if (req[j]) begin
                rr_hit = 1'b1;
                rr_idx = PW'(j);
            end
        end
    end

`ifdef SPLIT_MUX_ARB_LOCK_EN
    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    logic          state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;

    assign sel_idx = (state_q == ST_LOCK) ? owner_q : rr_idx;
    assign sel_hit = (state_q == ST_LOCK) ? req[owner_q] : rr_hit;
    assign locked  = (state_q == ST_LOCK);
`else
    logic unused_last;

    assign unused_last = ^last;
    assign sel_idx     = rr_idx;
    assign sel_hit     = rr_hit;
    assign locked      = 1'b0;
`endif

    // No grant without a credit, and none while reset is held.
    assign gnt_vld = rst_n && (credit_q != '0) && sel_hit;

    generate
        for (genvar gi = 0; gi < CNT; gi++) begin : g_onehot
            assign gnt[gi] = gnt_vld && (sel_idx == PW'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d = ptr_q;
`ifdef SPLIT_MUX_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        if (gnt_vld) begin
            if (state_q == ST_LOCK) begin
                if (last[owner_q]) begin
                    state_d = ST_ARB;
                    ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
                end
            end else begin
                ptr_d = (rr_idx == LAST_IDX) ? '0 : rr_idx + PW'(1);
                if (!last[rr_idx]) begin
                    state_d = ST_LOCK;
                    owner_d = rr_idx;
                end
            end
        end
`else
        if (gnt_vld) begin
            ptr_d = (rr_idx == LAST_IDX) ? '0 : rr_idx + PW'(1);
        end
`endif
    end

    // A beat and a return in the same cycle cancel out; a return while full is an error.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (gnt_vld && !credit_ret) begin
            credit_d = credit_q - CW'(1);
        end else if (!gnt_vld && credit_ret) begin
            if (credit_q == CRED_FULL) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            credit_q <= CRED_FULL;
            err_q    <= 1'b0;
`ifdef SPLIT_MUX_ARB_LOCK_EN
            state_q  <= ST_ARB;
            owner_q  <= '0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
`ifdef SPLIT_MUX_ARB_LOCK_EN
            state_q  <= state_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_split_mux_rr_arb.sv
// Self-checking bench for split_mux_rr_arb: directed scenarios plus randomized traffic
// against a behavioural round-robin/credit model.
module tb_split_mux_rr_arb;

    localparam int CNT     = 31;
    localparam int CREDITS = 8;
    localparam int CW      = $clog2(CREDITS + 1);

`ifdef SPLIT_MUX_ARB_LOCK_EN
    localparam logic EXP_LOCK_AFTER_OPEN_BURST = 1'b1;
`else
    localparam logic EXP_LOCK_AFTER_OPEN_BURST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [CNT-1:0] req;
    logic [CNT-1:0] last;
    logic           credit_ret;
    logic [CNT-1:0] gnt;
    logic           gnt_vld;
    logic [CW-1:0]  credit_cnt;
    logic           locked;
    logic           credit_err;

    always #5 clk = ~clk;

    split_mux_rr_arb #(.CNT(CNT), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .last       (last),
        .credit_ret (credit_ret),
        .gnt        (gnt),
        .gnt_vld    (gnt_vld),
        .credit_cnt (credit_cnt),
        .locked     (locked),
        .credit_err (credit_err)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_ptr;
    int m_owner;
    bit m_locked;
    int m_cred;
    bit m_err;

    // Per-cycle observations (grant side sampled before the edge, registers after it)
    logic [CNT-1:0] obs_gnt, exp_gnt;
    logic           obs_vld, exp_vld;
    logic [CW-1:0]  obs_cnt;
    logic           obs_locked;
    logic           obs_err;

    function automatic int model_winner(input logic r, input logic [CNT-1:0] rq);
        if (!r || m_cred == 0) return -1;
        if (m_locked) return rq[m_owner] ? m_owner : -1;
        for (int off = 0; off < CNT; off++) begin
            if (rq[(m_ptr + off) % CNT]) return (m_ptr + off) % CNT;
        end
        return -1;
    endfunction

    task automatic run_cycle(input logic r, input logic [CNT-1:0] rq,
                             input logic [CNT-1:0] lt, input logic ret);
        int w;
        @(negedge clk);
        rst_n      = r;
        req        = rq;
        last       = lt;
        credit_ret = ret;
        #1;
        w       = model_winner(r, rq);
        exp_vld = (w >= 0);
        exp_gnt = (w >= 0) ? (CNT'(1) << w) : '0;
        obs_gnt = gnt;
        obs_vld = gnt_vld;
        if (!r) begin
            m_ptr = 0; m_owner = 0; m_locked = 0; m_cred = CREDITS; m_err = 0;
        end else begin
            if (w >= 0) begin
                if (m_locked) begin
                    if (lt[m_owner]) begin
                        m_locked = 0;
                        m_ptr    = (m_owner + 1) % CNT;
                    end
                end else begin
                    m_ptr = (w + 1) % CNT;
`ifdef SPLIT_MUX_ARB_LOCK_EN
                    if (!lt[w]) begin
                        m_locked = 1;
                        m_owner  = w;
                    end
`endif
                end
            end
            if (w >= 0 && !ret) m_cred--;
            else if (w < 0 && ret) begin
                if (m_cred == CREDITS) m_err = 1;
                else m_cred++;
            end
        end
        @(posedge clk);
        #1;
        obs_cnt    = credit_cnt;
        obs_locked = locked;
        obs_err    = credit_err;
    endtask

    task automatic do_reset();
        run_cycle(1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        run_cycle(1'b0, '1, '1, 1'b0);
        checks++;
        if (obs_gnt !== '0) begin
            failures++; $display("FAIL reset_gnt_in_reset got=%h exp=0", obs_gnt);
        end
        run_cycle(1'b1, '0, '1, 1'b0);
        checks++;
        if (obs_gnt !== '0 || obs_vld !== 1'b0) begin
            failures++; $display("FAIL reset_gnt got=%h vld=%b exp=0", obs_gnt, obs_vld);
        end
        checks++;
        if (obs_cnt !== CW'(CREDITS)) begin
            failures++; $display("FAIL reset_credit got=%0d exp=%0d", obs_cnt, CREDITS);
        end
        checks++;
        if (obs_locked !== 1'b0 || obs_err !== 1'b0) begin
            failures++; $display("FAIL reset_flags locked=%b err=%b exp=0/0", obs_locked, obs_err);
        end
        $display("test_reset done");
    endtask

    task automatic test_rr_wrap();
        int seq [6] = '{0, 5, 30, 0, 5, 30};
        logic [CNT-1:0] rq;
        rq = '0;
        rq[0] = 1'b1; rq[5] = 1'b1; rq[30] = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, rq, '1, 1'b1);
            checks++;
            if (obs_gnt !== (CNT'(1) << seq[i])) begin
                failures++; $display("FAIL rr_seq[%0d] got=%h exp=%h", i, obs_gnt, CNT'(1) << seq[i]);
            end
            $display("rr beat %0d gnt=%h", i, obs_gnt);
        end
        checks++;
        if (obs_cnt !== CW'(CREDITS)) begin
            failures++; $display("FAIL rr_credit got=%0d exp=%0d", obs_cnt, CREDITS);
        end
    endtask

    task automatic test_credit_exhaust();
        logic [CNT-1:0] rq;
        int n;
        rq = '0;
        rq[7] = 1'b1;
        do_reset();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b1, rq, '1, 1'b0);
            n += int'(obs_vld);
        end
        checks++;
        if (n != CREDITS) begin
            failures++; $display("FAIL exhaust_grants got=%0d exp=%0d", n, CREDITS);
        end
        checks++;
        if (obs_gnt !== '0 || obs_cnt !== '0) begin
            failures++; $display("FAIL exhaust_stall gnt=%h cnt=%0d exp=0/0", obs_gnt, obs_cnt);
        end
        run_cycle(1'b1, rq, '1, 1'b1);
        checks++;
        if (obs_cnt !== CW'(1)) begin
            failures++; $display("FAIL exhaust_return got=%0d exp=1", obs_cnt);
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1, rq, '1, 1'b0);
            n += int'(obs_vld);
        end
        checks++;
        if (n != 1) begin
            failures++; $display("FAIL exhaust_one_more got=%0d exp=1", n);
        end
        $display("test_credit_exhaust done");
    endtask

    task automatic test_credit_err();
        do_reset();
        run_cycle(1'b1, '0, '0, 1'b1);
        checks++;
        if (obs_err !== 1'b1 || obs_cnt !== CW'(CREDITS)) begin
            failures++; $display("FAIL credit_err_set err=%b cnt=%0d exp=1/%0d", obs_err, obs_cnt, CREDITS);
        end
        for (int i = 0; i < 3; i++) run_cycle(1'b1, '0, '0, 1'b0);
        checks++;
        if (obs_err !== 1'b1) begin
            failures++; $display("FAIL credit_err_sticky got=%b exp=1", obs_err);
        end
        $display("test_credit_err done");
    endtask

    task automatic test_lock_burst();
        logic [CNT-1:0] rq, lt, b3, b4;
        b3 = CNT'(1) << 3;
        b4 = CNT'(1) << 4;
        rq = b3 | b4;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            lt = (k == 3) ? b3 : '0;
            run_cycle(1'b1, rq, lt, 1'b1);
`ifdef SPLIT_MUX_ARB_LOCK_EN
            checks++;
            if (obs_gnt !== b3) begin
                failures++; $display("FAIL lock_gnt[%0d] got=%h exp=%h", k, obs_gnt, b3);
            end
            checks++;
            if (obs_locked !== (k < 3)) begin
                failures++; $display("FAIL lock_flag[%0d] got=%b exp=%b", k, obs_locked, k < 3);
            end
`else
            checks++;
            if (obs_gnt !== ((k % 2 == 0) ? b3 : b4)) begin
                failures++; $display("FAIL nolock_gnt[%0d] got=%h", k, obs_gnt);
            end
            checks++;
            if (obs_locked !== 1'b0) begin
                failures++; $display("FAIL nolock_flag[%0d] got=%b exp=0", k, obs_locked);
            end
`endif
            $display("burst beat %0d gnt=%h locked=%b", k, obs_gnt, obs_locked);
        end
        run_cycle(1'b1, b4, '0, 1'b1);
        checks++;
        if (obs_gnt !== b4) begin
            failures++; $display("FAIL lock_next got=%h exp=%h", obs_gnt, b4);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [CNT-1:0] b1;
        b1 = CNT'(1) << 1;
        do_reset();
        for (int i = 0; i < 6; i++) run_cycle(1'b1, b1, '0, 1'b0);
        checks++;
        if (obs_cnt !== CW'(2) || obs_locked !== EXP_LOCK_AFTER_OPEN_BURST) begin
            failures++; $display("FAIL midlock_pre cnt=%0d locked=%b exp=2/%b", obs_cnt, obs_locked, EXP_LOCK_AFTER_OPEN_BURST);
        end
        run_cycle(1'b0, b1, '0, 1'b0);
        checks++;
        if (obs_gnt !== '0) begin
            failures++; $display("FAIL midlock_gnt_in_reset got=%h exp=0", obs_gnt);
        end
        checks++;
        if (obs_cnt !== CW'(CREDITS) || obs_locked !== 1'b0) begin
            failures++; $display("FAIL midlock_post cnt=%0d locked=%b exp=%0d/0", obs_cnt, obs_locked, CREDITS);
        end
        run_cycle(1'b1, CNT'(7), '1, 1'b1);
        checks++;
        if (obs_gnt !== CNT'(1)) begin
            failures++; $display("FAIL midlock_ptr0 got=%h exp=1", obs_gnt);
        end
        $display("test_reset_mid_lock done");
    endtask

    task automatic test_random();
        logic r, ret;
        logic [CNT-1:0] rq, lt;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            rq  = CNT'($urandom & $urandom);
            lt  = CNT'($urandom);
            ret = ($urandom_range(0, 1) == 1);
            run_cycle(r, rq, lt, ret);
            checks++;
            if (obs_gnt !== exp_gnt || obs_vld !== exp_vld) begin
                failures++; $display("FAIL rand_gnt[%0d] got=%h/%b exp=%h/%b", i, obs_gnt, obs_vld, exp_gnt, exp_vld);
            end
            checks++;
            if (obs_cnt !== CW'(m_cred)) begin
                failures++; $display("FAIL rand_credit[%0d] got=%0d exp=%0d", i, obs_cnt, m_cred);
            end
            checks++;
            if (obs_locked !== m_locked || obs_err !== m_err) begin
                failures++; $display("FAIL rand_flags[%0d] locked=%b err=%b exp=%b/%b", i, obs_locked, obs_err, m_locked, m_err);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; last = '0; credit_ret = 1'b0;
        m_ptr = 0; m_owner = 0; m_locked = 0; m_cred = CREDITS; m_err = 0;
        test_reset();
        test_rr_wrap();
        test_credit_exhaust();
        test_credit_err();
        test_lock_burst();
        test_reset_mid_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
